// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core datapath and the DMEM word port.
// Latency: the response arrives 1+N cycles after accept; N is the number of DMEM cycles (0 for an error, 1 aligned, 2 spanning load, n bytes for a misaligned store).
// Backpressure: one request is in flight at a time; req_ready is high only in IDLE, and rsp_valid is a single-cycle pulse that is never stalled.

`ifndef LOAD_SEL_W
`define LOAD_SEL_W 3'b010
`endif
`ifndef STORE_SEL_B
`define STORE_SEL_B 2'b00
`endif
`ifndef STORE_SEL_H
`define STORE_SEL_H 2'b01
`endif
`ifndef STORE_SEL_W
`define STORE_SEL_W 2'b10
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module lsu_mem_ctrl #(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_load_sel,
  output logic [1:0]  mem_store_sel,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_ST,
    S_STB,
    S_RESP
  } state_t;

  state_t      state, state_nxt;

  logic        we_q, uns_q, err_q, span_q;
  logic [1:0]  size_q, k_q, last_k;
  logic [31:0] addr_q, wdata_q, w0_q, w1_q;

  logic [1:0]  req_off;
  logic [2:0]  req_n;
  logic        req_illegal, req_mis, req_span, req_reject;
  logic        accept;

  logic [31:0] ldata, lext;
  logic [7:0]  wbyte;

  // Request decode: byte count, alignment, and whether the access crosses a word.
  assign req_off     = req_addr[1:0];
  assign req_n       = (req_size == 2'b00) ? 3'd1 : (req_size == 2'b01) ? 3'd2 : 3'd4;
  assign req_illegal = (req_size == 2'b11);
  assign req_mis     = ((req_size == 2'b01) && req_off[0]) ||
                       ((req_size == 2'b10) && (req_off != 2'b00));
  assign req_span    = (({1'b0, req_off} + req_n) > 3'd4);
  assign req_reject  = req_illegal || (req_mis && !ALLOW_MISALIGN);
  assign accept      = req_valid && (state == S_IDLE);

  // Index of the final byte in a byte-split store.
  assign last_k = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;

  // Load lane extraction across the two captured words, followed by sign or zero extension.
  assign ldata = 32'({w1_q, w0_q} >> {addr_q[1:0], 3'b000});
  assign wbyte = 8'(wdata_q >> {k_q, 3'b000});

  // Extend the extracted load data to 32 bits according to the access size.
  always_comb begin
    lext = ldata;
    case (size_q)
      2'b00:   lext = {{24{~uns_q & ldata[7]}}, ldata[7:0]};
      2'b01:   lext = {{16{~uns_q & ldata[15]}}, ldata[15:0]};
      default: lext = ldata;
    endcase
  end

  assign mem_load_sel = `LOAD_SEL_W;

  // State register and per-request context. Reset aborts any access in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      span_q  <= 1'b0;
      size_q  <= 2'b10;
      k_q     <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      w0_q    <= 32'd0;
      w1_q    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_reject;
        span_q  <= req_span;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        k_q     <= 2'd0;
      end
      if (state == S_RD0) w0_q <= mem_rdata;
      if (state == S_RD1) w1_q <= mem_rdata;
      if (state == S_STB) k_q <= k_q + 2'd1;
    end
  end

  // Next-state logic and all state-dependent outputs; DMEM is driven only in the read and store states.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = 32'd0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    mem_store_sel = `STORE_SEL_W;
    mem_wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_reject)   state_nxt = S_RESP;
          else if (!req_we) state_nxt = S_RD0;
          else if (req_mis) state_nxt = S_STB;
          else              state_nxt = S_ST;
        end
      end
      S_RD0: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        state_nxt = span_q ? S_RD1 : S_RESP;
      end
      S_RD1: begin
        mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
        state_nxt = S_RESP;
      end
      S_ST: begin
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        mem_wr_en     = `MEM_WRITE;
        mem_store_sel = (size_q == 2'b00) ? `STORE_SEL_B :
                        (size_q == 2'b01) ? `STORE_SEL_H : `STORE_SEL_W;
        state_nxt     = S_RESP;
      end
      S_STB: begin
        mem_addr      = addr_q + {30'd0, k_q};
        mem_wdata     = {24'd0, wbyte};
        mem_wr_en     = `MEM_WRITE;
        mem_store_sel = `STORE_SEL_B;
        state_nxt     = (k_q == last_k) ? S_RESP : S_STB;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? 32'd0 : lext;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a byte-level reference memory predicts responses and stores.
// A per-cycle compare process checks response timing and data against the predictions.
// Directed requests carry hand-computed literal expectations for data, latency and store lane width.
module tb_lsu_mem_ctrl;

  localparam logic [2:0] LSEL_W = 3'b010;
  localparam logic [1:0] SSEL_B = 2'b00;
  localparam logic [1:0] SSEL_H = 2'b01;
  localparam logic [1:0] SSEL_W = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, mem_wr_en;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_load_sel;
  logic [1:0]  mem_store_sel;

  logic        nm_req_valid = 1'b0, nm_req_we = 1'b0;
  logic [1:0]  nm_req_size = 2'b10;
  logic [31:0] nm_req_addr = 32'd0, nm_req_wdata = 32'd0;
  logic        nm_req_ready, nm_rsp_valid, nm_rsp_err, nm_mem_wr_en;
  logic [31:0] nm_rsp_rdata, nm_mem_addr, nm_mem_wdata;
  logic [31:0] nm_mem_rdata = 32'h44332211;
  logic [2:0]  nm_mem_load_sel;
  logic [1:0]  nm_mem_store_sel;

  int checks = 0, failures = 0;
  int cyc = 0, rsp_count = 0, wr_count = 0, nm_wr_count = 0;
  int last_cyc = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  logic [1:0]  last_sel = 2'b11;

  logic [31:0] dmem [64];
  logic [7:0]  rmem [256];

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t expq[$];

  lsu_mem_ctrl #(.ALLOW_MISALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_load_sel(mem_load_sel), .mem_store_sel(mem_store_sel),
    .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
  );

  lsu_mem_ctrl #(.ALLOW_MISALIGN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_we(nm_req_we),
    .req_size(nm_req_size), .req_unsigned(1'b0), .req_addr(nm_req_addr), .req_wdata(nm_req_wdata),
    .rsp_valid(nm_rsp_valid), .rsp_rdata(nm_rsp_rdata), .rsp_err(nm_rsp_err), .mem_addr(nm_mem_addr),
    .mem_wdata(nm_mem_wdata), .mem_load_sel(nm_mem_load_sel), .mem_store_sel(nm_mem_store_sel),
    .mem_wr_en(nm_mem_wr_en), .mem_rdata(nm_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // DMEM word port model: combinational read, byte/half/word write on the clock edge.
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      wr_count++;
      last_sel = mem_store_sel;
      case (mem_store_sel)
        SSEL_B:  dmem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
        SSEL_H:  dmem[mem_addr[7:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
        default: dmem[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
    if (nm_mem_wr_en) nm_wr_count++;
  end

  // Per-cycle compare against the predicted response schedule.
  always @(negedge clk) begin
    if (!rst) begin
      chk("load_sel", {29'd0, mem_load_sel}, {29'd0, LSEL_W});
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        last_cyc   = cyc;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        chk("rsp_valid_due", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata_model", rsp_rdata, expq[0].rdata);
        chk("rsp_err_model", {31'd0, rsp_err}, {31'd0, expq[0].err});
        chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        void'(expq.pop_front());
      end else begin
        chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
      end
    end
  end

  // Reference: read n bytes little-endian from the byte memory and extend.
  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit uns);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(rmem[(a + i) & 32'hFF]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] lit_rdata, input int lit_lat,
                        input bit lit_err, input int lit_sel);
    int   n, off, nmem, nwr, t, g, rc0, wc0;
    bit   aligned, span, err;
    exp_t e;
    n       = 1 << sz;
    off     = int'(a[1:0]);
    aligned = (sz != 2'b11) && ((off % n) == 0);
    span    = (off + n) > 4;
    err     = (sz == 2'b11);
    if (err) begin
      nmem = 0;
      nwr  = 0;
    end else if (!we) begin
      nmem = span ? 2 : 1;
      nwr  = 0;
    end else begin
      nmem = aligned ? 1 : n;
      nwr  = nmem;
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    g = 0;
    while (req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    t       = cyc;
    e.cyc   = t + 1 + nmem;
    e.err   = err;
    e.rdata = (err || we) ? 32'd0 : model_load(a, n, uns);
    expq.push_back(e);
    if (we && !err)
      for (int i = 0; i < n; i++) rmem[(a + i) & 32'hFF] = wd[8*i +: 8];
    rc0 = rsp_count;
    wc0 = wr_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    g = 0;
    while (rsp_count == rc0 && g < 30) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("rsp_timeout", {31'd0, (rsp_count != rc0)}, 32'd1);
    chk("latency_lit", 32'(last_cyc - t), 32'(lit_lat));
    chk("rdata_lit", last_rdata, lit_rdata);
    chk("err_lit", {31'd0, last_err}, {31'd0, lit_err});
    chk("write_count", 32'(wr_count - wc0), 32'(nwr));
    if (lit_sel >= 0) chk("store_sel_lit", {30'd0, last_sel}, 32'(lit_sel));
  endtask

  task automatic nm_req(input bit we, input logic [1:0] sz, input logic [31:0] a,
                        input int lit_lat, input bit lit_err, input logic [31:0] lit_rdata);
    int t, g;
    @(negedge clk);
    nm_req_valid = 1'b1; nm_req_we = we; nm_req_size = sz; nm_req_addr = a; nm_req_wdata = 32'hDEADBEEF;
    chk("nm_req_ready", {31'd0, nm_req_ready}, 32'd1);
    t = cyc;
    @(posedge clk);
    #1 nm_req_valid = 1'b0;
    g = 0;
    @(negedge clk);
    while (nm_rsp_valid !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("nm_rsp_valid", {31'd0, nm_rsp_valid}, 32'd1);
    chk("nm_latency", 32'(cyc - t), 32'(lit_lat));
    chk("nm_err", {31'd0, nm_rsp_err}, {31'd0, lit_err});
    chk("nm_rdata", nm_rsp_rdata, lit_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int w = 0; w < 64; w++) dmem[w] = 32'd0;
    dmem[4] = 32'h44332211;
    dmem[5] = 32'h88776655;
    for (int b = 0; b < 256; b++) rmem[b] = 8'h00;
    for (int b = 0; b < 4; b++) begin
      rmem[16 + b] = 8'(32'h44332211 >> (8 * b));
      rmem[20 + b] = 8'(32'h88776655 >> (8 * b));
    end

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_store_sel", {30'd0, mem_store_sel}, {30'd0, SSEL_W});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    //     we    sz     uns   addr           wdata          lit_rdata      lat err sel
    do_req(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,         32'h44332211, 2, 0, -1);
    do_req(1'b0, 2'b10, 1'b0, 32'h00000013, 32'h0,         32'h77665544, 3, 0, -1);
    do_req(1'b0, 2'b01, 1'b0, 32'h00000013, 32'h0,         32'h00005544, 3, 0, -1);
    do_req(1'b0, 2'b00, 1'b0, 32'h00000017, 32'h0,         32'hFFFFFF88, 2, 0, -1);
    do_req(1'b0, 2'b00, 1'b1, 32'h00000017, 32'h0,         32'h00000088, 2, 0, -1);
    do_req(1'b1, 2'b01, 1'b0, 32'h00000012, 32'h00001234,  32'h0,        2, 0, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,         32'h12342211, 2, 0, -1);
    do_req(1'b1, 2'b10, 1'b0, 32'h00000011, 32'hAABBCCDD,  32'h0,        5, 0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,         32'hBBCCDD11, 2, 0, -1);
    do_req(1'b0, 2'b10, 1'b0, 32'h00000014, 32'h0,         32'h887766AA, 2, 0, -1);
    do_req(1'b0, 2'b11, 1'b0, 32'h00000010, 32'h0,         32'h0,        1, 1, -1);
    do_req(1'b1, 2'b11, 1'b0, 32'h00000014, 32'h12345678,  32'h0,        1, 1, -1);
    do_req(1'b0, 2'b01, 1'b0, 32'h00000011, 32'h0,         32'hFFFFCCDD, 2, 0, -1);
    do_req(1'b1, 2'b01, 1'b0, 32'h00000011, 32'h00005566,  32'h0,        3, 0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h00000011, 32'h0,         32'h00005566, 2, 0, -1);
    do_req(1'b1, 2'b00, 1'b0, 32'h00000016, 32'h0000007F,  32'h0,        2, 0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h00000016, 32'h0,         32'h0000007F, 2, 0, -1);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h01020304,  32'h0,        5, 0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0,         32'h01020304, 3, 0, -1);
    do_req(1'b1, 2'b10, 1'b0, 32'h00000020, 32'hCAFEF00D,  32'h0,        2, 0, 2);

    // Abort a byte-split store after its second byte.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h00000031; req_wdata = 32'h11223344;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    t0 = rsp_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("abort_wr_en_before", {31'd0, mem_wr_en}, 32'd1);
    rst = 1'b1;
    #1 chk("abort_wr_en_async", {31'd0, mem_wr_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_req_ready_after", {31'd0, req_ready}, 32'd1);
    rmem[8'h31] = 8'h44;
    rmem[8'h32] = 8'h33;
    repeat (8) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_count - t0), 32'd0);

    // Final DMEM contents against the reference byte memory.
    for (int w = 0; w < 64; w++)
      chk($sformatf("mem_word_%0d", w), dmem[w],
          {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]});
    chk("lit_mem_0x10", dmem[4], 32'hBB556611);
    chk("lit_mem_0x14", dmem[5], 32'h887F66AA);
    chk("lit_mem_0x30", dmem[12], 32'h00334400);

    // Instance that rejects misaligned accesses.
    nm_req(1'b0, 2'b01, 32'h00000011, 1, 1'b1, 32'h0);
    nm_req(1'b1, 2'b10, 32'h00000011, 1, 1'b1, 32'h0);
    nm_req(1'b0, 2'b10, 32'h00000010, 2, 1'b0, 32'h44332211);
    nm_req(1'b0, 2'b01, 32'h00000012, 2, 1'b0, 32'h00004433);
    chk("nm_no_writes", 32'(nm_wr_count), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
